// File: rtl/graphics_command_sequencer.sv
// Graphics command sequencer: decodes host op codes into frame-buffer writes,
// full-buffer clears, palette assignments and buffer-switch requests.
`timescale 1ns/1ps
module graphics_command_sequencer #(
  parameter int unsigned PIXEL_COUNT   = 256000,
  parameter int unsigned ADDRESS_WIDTH = 18,
  parameter int unsigned COLOR_WIDTH   = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [7:0]               op_code_in,
  input  logic                     op_code_valid_in,
  input  logic [7:0]               operand_in,
  input  logic                     operand_valid_in,
  input  logic [31:0]              operand_count_in,
  output logic                     pixel_write_enable_out,
  output logic [ADDRESS_WIDTH-1:0] pixel_write_address_out,
  output logic [COLOR_WIDTH-1:0]   pixel_write_data_out,
  input  logic                     pixel_write_buffer_ready_in,
  output logic                     assign_color_enable_out,
  output logic [7:0]               assign_color_index_out,
  output logic [9:0]               assign_color_value_out,
  output logic                     switch_write_buffer_out,
  output logic                     busy_out,
  output logic                     command_dropped_out
);

  // state | meaning
  // IDLE  | no frame-buffer traffic; a pending buffer switch is issued here
  // PIXEL | single pixel write held until the frame buffer accepts it
  // CLEAR | fill of every pixel with the clear color, one per accepted cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PIXEL = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [7:0] OP_ASSIGN = 8'h10;
  localparam logic [7:0] OP_DRAW   = 8'h11;
  localparam logic [7:0] OP_CLEAR  = 8'h12;
  localparam logic [7:0] OP_SHOW   = 8'h17;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(PIXEL_COUNT - 1);

  logic [1:0]               state_q, state_d;
  logic                     op_valid_q, operand_valid_q;
  logic [1:0]               addr_hi_q, addr_hi_d;
  logic [7:0]               addr_mid_q, addr_mid_d;
  logic [7:0]               addr_lo_q, addr_lo_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [COLOR_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                     pending_q, pending_d;
  logic                     color_en_q, color_en_d;
  logic [7:0]               color_idx_q, color_idx_d;
  logic [9:0]               color_val_q, color_val_d;
  logic                     drop_q, drop_d;

  logic        is_idle;
  logic        txn_start;
  logic        operand_stb;
  logic [17:0] draw_addr;
  logic        draw_in_range;

  assign is_idle       = (state_q == ST_IDLE);
  assign txn_start     = op_code_valid_in && !op_valid_q;
  assign operand_stb   = op_code_valid_in && operand_valid_in && !operand_valid_q;
  assign draw_addr     = {addr_hi_q, addr_mid_q, addr_lo_q};
  assign draw_in_range = (32'(draw_addr) < PIXEL_COUNT);

  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    addr_mid_d  = addr_mid_q;
    addr_lo_d   = addr_lo_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    pending_d   = pending_q;
    color_en_d  = 1'b0;
    color_idx_d = color_idx_q;
    color_val_d = color_val_q;
    drop_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) pending_d = 1'b0;
      end
      ST_PIXEL: begin
        if (pixel_write_buffer_ready_in) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (pixel_write_buffer_ready_in) begin
          if (wr_addr_q == LAST_ADDR) state_d = ST_IDLE;
          else wr_addr_d = wr_addr_q + ADDRESS_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A show request in IDLE goes through the pending flag and fires next cycle.
    if (txn_start && op_code_in == OP_SHOW) pending_d = 1'b1;

    if (operand_stb) begin
      case (op_code_in)
        OP_ASSIGN: begin
          case (operand_count_in)
            32'd1: color_idx_d = operand_in;
            32'd2: color_val_d[9:6] = operand_in[7:4];
            32'd3: color_val_d[5:3] = operand_in[7:5];
            32'd4: begin
              color_val_d[2:0] = operand_in[7:5];
              color_en_d       = 1'b1;
            end
            default: ;
          endcase
        end
        OP_DRAW: begin
          case (operand_count_in)
            32'd1: addr_hi_d  = operand_in[1:0];
            32'd2: addr_mid_d = operand_in;
            32'd3: addr_lo_d  = operand_in;
            32'd4: begin
              if (is_idle && draw_in_range) begin
                state_d   = ST_PIXEL;
                wr_addr_d = ADDRESS_WIDTH'(draw_addr);
                wr_data_d = COLOR_WIDTH'(operand_in[3:0]);
              end else begin
                drop_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        OP_CLEAR: begin
          if (operand_count_in == 32'd1) begin
            if (is_idle) begin
              state_d   = ST_CLEAR;
              wr_addr_d = '0;
              wr_data_d = COLOR_WIDTH'(operand_in[3:0]);
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q         <= ST_IDLE;
      op_valid_q      <= 1'b0;
      operand_valid_q <= 1'b0;
      addr_hi_q       <= '0;
      addr_mid_q      <= '0;
      addr_lo_q       <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      pending_q       <= 1'b0;
      color_en_q      <= 1'b0;
      color_idx_q     <= '0;
      color_val_q     <= '0;
      drop_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_valid_q      <= op_code_valid_in;
      operand_valid_q <= operand_valid_in;
      addr_hi_q       <= addr_hi_d;
      addr_mid_q      <= addr_mid_d;
      addr_lo_q       <= addr_lo_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      pending_q       <= pending_d;
      color_en_q      <= color_en_d;
      color_idx_q     <= color_idx_d;
      color_val_q     <= color_val_d;
      drop_q          <= drop_d;
    end
  end

  assign pixel_write_enable_out  = !is_idle;
  assign pixel_write_address_out = wr_addr_q;
  assign pixel_write_data_out    = wr_data_q;
  assign busy_out                = !is_idle;
  // Only asserted in IDLE, so it can never overlap a write request.
  assign switch_write_buffer_out = is_idle && pending_q;
  assign assign_color_enable_out = color_en_q;
  assign assign_color_index_out  = color_idx_q;
  assign assign_color_value_out  = color_val_q;
  assign command_dropped_out     = drop_q;

endmodule

// File: tb/tb_graphics_command_sequencer.sv
// Self-checking bench for graphics_command_sequencer: directed tables, corner
// sequences and randomized traffic against a work-count reference model.
`timescale 1ns/1ps
module tb_graphics_command_sequencer;

  localparam int SMALL_PC = 600;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  op;
  logic        opv;
  logic [7:0]  opd;
  logic        ov;
  logic [31:0] cnt;
  logic        rdy;

  logic        b_en, b_aen, b_sw, b_busy, b_drop;
  logic [17:0] b_addr;
  logic [3:0]  b_data;
  logic [7:0]  b_idx;
  logic [9:0]  b_val;
  logic        s_en, s_aen, s_sw, s_busy, s_drop;
  logic [17:0] s_addr;
  logic [3:0]  s_data;
  logic [7:0]  s_idx;
  logic [9:0]  s_val;

  graphics_command_sequencer u_big (
    .clock_in(clk), .reset_in(rst),
    .op_code_in(op), .op_code_valid_in(opv),
    .operand_in(opd), .operand_valid_in(ov), .operand_count_in(cnt),
    .pixel_write_enable_out(b_en), .pixel_write_address_out(b_addr),
    .pixel_write_data_out(b_data), .pixel_write_buffer_ready_in(rdy),
    .assign_color_enable_out(b_aen), .assign_color_index_out(b_idx),
    .assign_color_value_out(b_val), .switch_write_buffer_out(b_sw),
    .busy_out(b_busy), .command_dropped_out(b_drop)
  );

  graphics_command_sequencer #(.PIXEL_COUNT(SMALL_PC)) u_small (
    .clock_in(clk), .reset_in(rst),
    .op_code_in(op), .op_code_valid_in(opv),
    .operand_in(opd), .operand_valid_in(ov), .operand_count_in(cnt),
    .pixel_write_enable_out(s_en), .pixel_write_address_out(s_addr),
    .pixel_write_data_out(s_data), .pixel_write_buffer_ready_in(rdy),
    .assign_color_enable_out(s_aen), .assign_color_index_out(s_idx),
    .assign_color_value_out(s_val), .switch_write_buffer_out(s_sw),
    .busy_out(s_busy), .command_dropped_out(s_drop)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit sel_big;
  int pc;
  int rdy_mode;

  // reference model: outstanding write count plus request flags
  int         m_work, m_paddr;
  bit         m_clear, m_req, e_aen, e_drop, p_opv, p_ov;
  logic [3:0] m_col;
  logic [7:0] m_c[4];
  logic [7:0] m_a[3];
  logic [7:0] m_idx;
  logic [9:0] m_val;

  logic        o_en, o_busy, o_sw, o_drop, o_aen;
  logic [17:0] o_addr;
  logic [3:0]  o_data;
  logic [7:0]  o_idx;
  logic [9:0]  o_val;

  int n_sw, n_drop, n_aen, n_en, last_acc_cyc, sw_cyc;
  logic [7:0]  last_idx;
  logic [9:0]  last_val;
  logic [17:0] acc_addr[$];
  logic [3:0]  acc_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [44:0] obs_packed();
    return {o_en, o_busy, o_sw, o_drop, o_aen,
            o_en ? o_addr : 18'd0, o_en ? o_data : 4'd0,
            o_aen ? o_idx : 8'd0, o_aen ? o_val : 10'd0};
  endfunction

  function automatic logic [44:0] exp_packed();
    bit   en;
    int   a;
    en = (m_work > 0);
    a  = m_clear ? (pc - m_work) : m_paddr;
    return {en, en, m_req && !en, e_drop, e_aen,
            en ? 18'(a) : 18'd0, en ? m_col : 4'd0,
            e_aen ? m_idx : 8'd0, e_aen ? m_val : 10'd0};
  endfunction

  task automatic sample();
    if (sel_big) begin
      o_en = b_en; o_busy = b_busy; o_sw = b_sw; o_drop = b_drop; o_aen = b_aen;
      o_addr = b_addr; o_data = b_data; o_idx = b_idx; o_val = b_val;
    end else begin
      o_en = s_en; o_busy = s_busy; o_sw = s_sw; o_drop = s_drop; o_aen = s_aen;
      o_addr = s_addr; o_data = s_data; o_idx = s_idx; o_val = s_val;
    end
  endtask

  task automatic model_step();
    bit busy, start, stb, sw_now;
    int k, a;
    if (rst) begin
      m_work = 0; m_req = 0; e_aen = 0; e_drop = 0; p_opv = 0; p_ov = 0;
      for (int i = 0; i < 4; i++) m_c[i] = 8'h00;
      for (int i = 0; i < 3; i++) m_a[i] = 8'h00;
      return;
    end
    busy   = (m_work > 0);
    sw_now = m_req && !busy;
    start  = opv && !p_opv;
    stb    = opv && ov && !p_ov;
    e_aen  = 0;
    e_drop = 0;
    if (busy && rdy) m_work--;
    if (start && op == 8'h17) m_req = 1;
    else if (sw_now) m_req = 0;
    k = int'(cnt);
    if (stb && cnt >= 1 && cnt <= 4) begin
      case (op)
        8'h10: begin
          m_c[k-1] = opd;
          if (k == 4) begin
            m_idx = m_c[0];
            m_val = 10'(int'(m_c[1] >> 4) * 64 + int'(m_c[2] >> 5) * 8 + int'(m_c[3] >> 5));
            e_aen = 1;
          end
        end
        8'h11: begin
          if (k < 4) m_a[k-1] = opd;
          else begin
            a = int'(m_a[0] % 4) * 65536 + int'(m_a[1]) * 256 + int'(m_a[2]);
            if (busy || a >= pc) e_drop = 1;
            else begin m_work = 1; m_clear = 0; m_paddr = a; m_col = opd[3:0]; end
          end
        end
        8'h12: begin
          if (k == 1) begin
            if (busy) e_drop = 1;
            else begin m_work = pc; m_clear = 1; m_col = opd[3:0]; end
          end
        end
        default: ;
      endcase
    end
    p_opv = opv;
    p_ov  = ov;
  endtask

  task automatic tick();
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = 1'b0;
      2: rdy = ~rdy;
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    if (!rst && o_en && rdy) begin
      acc_addr.push_back(o_addr);
      acc_data.push_back(o_data);
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    sample();
    if (o_sw) begin n_sw++; sw_cyc = cyc; end
    if (o_drop) n_drop++;
    if (o_aen) begin n_aen++; last_idx = o_idx; last_val = o_val; end
    if (o_en) n_en++;
    check("cycle_outputs", 64'(obs_packed()), 64'(exp_packed()));
  endtask

  task automatic send_cmd(input logic [7:0] code, input int n,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input int hold, input bit lead);
    logic [7:0] bb[4];
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    op = code; opv = 1'b1; ov = 1'b0;
    if (!lead || n == 0) tick();
    for (int i = 0; i < n; i++) begin
      cnt = 32'(i + 1);
      opd = (i < 4) ? bb[i] : 8'($urandom);
      ov  = 1'b1;
      for (int h = 0; h < hold; h++) tick();
      ov = 1'b0;
      tick();
    end
    opv = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k = 0;
    while (o_busy && k < bound) begin tick(); k++; end
    check(name, 64'(o_busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; opv = 1'b0; ov = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic clear_stats();
    n_sw = 0; n_drop = 0; n_aen = 0; n_en = 0; sw_cyc = -1; last_acc_cyc = -1;
    acc_addr.delete(); acc_data.delete();
  endtask

  typedef struct {
    logic [7:0] b1, b2, b3, b4;
    logic [7:0] idx;
    logic [9:0] val;
  } assign_vec_t;

  typedef struct {
    logic [17:0] addr;
    logic [3:0]  col;
    bit          drop;
  } draw_vec_t;

  initial begin
    assign_vec_t av[4];
    draw_vec_t   dv[6];
    int          bad, c0;
    logic [17:0] a18;
    logic [7:0]  code;
    int          n, r;

    av[0] = '{8'h05, 8'hA0, 8'h60, 8'hE0, 8'h05, 10'h29F};
    av[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FF};
    av[2] = '{8'h00, 8'h0F, 8'h1F, 8'h1F, 8'h00, 10'h000};
    av[3] = '{8'h3C, 8'h5A, 8'hA5, 8'h40, 8'h3C, 10'h16A};

    dv[0] = '{18'd0,       4'h3, 1'b0};
    dv[1] = '{18'd599,     4'hF, 1'b0};
    dv[2] = '{18'd600,     4'h1, 1'b1};
    dv[3] = '{18'h3FFFF,   4'h2, 1'b1};
    dv[4] = '{18'h12345,   4'h5, 1'b1};
    dv[5] = '{18'h155,     4'hA, 1'b0};

    op = 8'h00; opv = 1'b0; opd = 8'h00; ov = 1'b0; cnt = 32'd0; rdy = 1'b0; rst = 1'b1;
    rdy_mode = 0; sel_big = 1'b1; pc = 256000;
    m_work = 0; m_paddr = 0; m_clear = 0; m_req = 0; e_aen = 0; e_drop = 0;
    p_opv = 0; p_ov = 0; m_col = 4'h0; m_idx = 8'h00; m_val = 10'h000;
    clear_stats();

    do_reset();
    check("reset_state", 64'(obs_packed()), 64'd0);

    // palette assignments on the full-size instance
    for (int i = 0; i < 4; i++) begin
      clear_stats();
      send_cmd(8'h10, 4, av[i].b1, av[i].b2, av[i].b3, av[i].b4, 1 + i % 2, i[0]);
      check($sformatf("assign_pulses[%0d]", i), 64'(n_aen), 64'd1);
      check($sformatf("assign_index[%0d]", i), 64'(last_idx), 64'(av[i].idx));
      check($sformatf("assign_value[%0d]", i), 64'(last_val), 64'(av[i].val));
    end

    // draw 0x12345 with ready low for three enable cycles
    clear_stats();
    rdy_mode = 1;
    send_cmd(8'h11, 4, 8'h01, 8'h23, 8'h45, 8'h0C, 1, 1'b0);
    tick();
    rdy_mode = 0;
    tick();
    check("draw_enable_cycles", 64'(n_en), 64'd4);
    check("draw_accept_count", 64'(acc_addr.size()), 64'd1);
    if (acc_addr.size() == 1) begin
      check("draw_address", 64'(acc_addr[0]), 64'h12345);
      check("draw_data", 64'(acc_data[0]), 64'hC);
    end
    check("draw_busy_after_accept", 64'(o_busy), 64'd0);

    clear_stats();
    send_cmd(8'h11, 4, 8'h03, 8'hFF, 8'hFF, 8'h09, 1, 1'b0);
    repeat (2) tick();
    check("oor_drop_pulses", 64'(n_drop), 64'd1);
    check("oor_no_write", 64'(n_en), 64'd0);

    // remaining tests on the reduced-size instance
    sel_big = 1'b0; pc = SMALL_PC;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      clear_stats();
      send_cmd(8'h11, 4, {6'd0, dv[i].addr[17:16]}, dv[i].addr[15:8], dv[i].addr[7:0],
               {4'h0, dv[i].col}, 1, i[0]);
      repeat (2) tick();
      check($sformatf("draw_tbl_drop[%0d]", i), 64'(n_drop), 64'(dv[i].drop));
      check($sformatf("draw_tbl_writes[%0d]", i), 64'(acc_addr.size()), 64'(!dv[i].drop));
      if (!dv[i].drop && acc_addr.size() == 1) begin
        check($sformatf("draw_tbl_addr[%0d]", i), 64'(acc_addr[0]), 64'(dv[i].addr));
        check($sformatf("draw_tbl_data[%0d]", i), 64'(acc_data[0]), 64'(dv[i].col));
      end
    end

    // clear with alternating ready
    clear_stats();
    rdy_mode = 2;
    send_cmd(8'h12, 1, 8'h07, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    wait_idle(3 * SMALL_PC + 20, "clear_timeout");
    check("clear_write_count", 64'(acc_addr.size()), 64'(SMALL_PC));
    bad = 0;
    for (int i = 0; i < acc_addr.size(); i++) begin
      if (int'(acc_addr[i]) != i) bad++;
      if (acc_data[i] != 4'h7) bad++;
    end
    check("clear_order_and_color", 64'(bad), 64'd0);

    // two show requests and a draw while clearing
    clear_stats();
    rdy_mode = 3;
    send_cmd(8'h12, 1, 8'h02, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    send_cmd(8'h17, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    tick();
    send_cmd(8'h17, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    send_cmd(8'h11, 4, 8'h00, 8'h00, 8'h05, 8'h01, 1, 1'b0);
    check("deferred_no_early_switch", 64'(n_sw), 64'd0);
    wait_idle(4 * SMALL_PC, "deferred_clear_timeout");
    repeat (3) tick();
    check("deferred_switch_pulses", 64'(n_sw), 64'd1);
    check("deferred_switch_timing", 64'(sw_cyc), 64'(last_acc_cyc + 1));
    check("deferred_draw_dropped", 64'(n_drop), 64'd1);

    // reset in the middle of a clear with a switch pending
    clear_stats();
    rdy_mode = 0;
    send_cmd(8'h12, 1, 8'h0B, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    send_cmd(8'h17, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    c0 = 0;
    while (!(o_en && o_addr >= 18'd300) && c0 < 2000) begin tick(); c0++; end
    check("midclear_reached", 64'(o_en), 64'd1);
    rst = 1'b1;
    tick();
    check("reset_midclear_outputs", 64'(obs_packed()), 64'd0);
    rst = 1'b0;
    n_sw = 0;
    repeat (5) tick();
    check("no_stale_switch", 64'(n_sw), 64'd0);
    c0 = cyc;
    send_cmd(8'h17, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0);
    check("switch_after_reset_count", 64'(n_sw), 64'd1);
    check("switch_after_reset_latency", 64'(sw_cyc), 64'(c0 + 1));

    // randomized traffic against the model
    rdy_mode = 3;
    for (int t = 0; t < 280; t++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
        continue;
      end
      r = $urandom_range(0, 99);
      if (r < 30) code = 8'h10;
      else if (r < 60) code = 8'h11;
      else if (r < 67) code = 8'h12;
      else if (r < 82) code = 8'h17;
      else code = 8'($urandom_range(32, 255));
      case (code)
        8'h10, 8'h11: n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : 4;
        8'h12: n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 1;
        8'h17: n = 0;
        default: n = $urandom_range(0, 3);
      endcase
      r = $urandom_range(0, 9);
      if (r == 0) a18 = 18'h3FFFF;
      else if (r == 1) a18 = 18'(SMALL_PC - 1);
      else if (r == 2) a18 = 18'(SMALL_PC);
      else a18 = 18'($urandom_range(0, SMALL_PC + 50));
      if (code == 8'h11)
        send_cmd(code, n, {6'd0, a18[17:16]}, a18[15:8], a18[7:0], 8'($urandom),
                 $urandom_range(1, 2), 1'($urandom_range(0, 1)));
      else
        send_cmd(code, n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(1, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(4 * SMALL_PC, "random_drain_timeout");
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/graphics_command_sequencer.md
Name: graphics_command_sequencer

Overview:
- Sits between the host command interface (op code / operand stream) and the graphics datapath (frame buffers, color pallet).
- Decodes graphics op codes and sequences the datapath: single-pixel writes, full-buffer clear fills, palette assignments and buffer-switch requests.
- Applies a valid/ready handshake to the frame buffer write port.
- Holds off buffer switches until any in-flight write or clear has drained.

Parameters:
- PIXEL_COUNT, 256000: number of addressable pixels (640x400); clear range and address limit.
- ADDRESS_WIDTH, 18: pixel address width.
- COLOR_WIDTH, 4: indexed color width.

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  synchronous reset, active-high
- op_code_in  input  8  current op code
- op_code_valid_in  input  1  high for the whole command transaction
- operand_in  input  8  operand byte
- operand_valid_in  input  1  operand present
- operand_count_in  input  32  1-based operand index within the transaction
- pixel_write_enable_out  output  1  write request to frame buffer
- pixel_write_address_out  output  ADDRESS_WIDTH  write address
- pixel_write_data_out  output  COLOR_WIDTH  write color index
- pixel_write_buffer_ready_in  input  1  frame buffer can accept a write
- assign_color_enable_out  output  1  one-cycle palette write strobe
- assign_color_index_out  output  8  palette entry
- assign_color_value_out  output  10  YCbCr value {Y[3:0],Cb[2:0],Cr[2:0]}
- switch_write_buffer_out  output  1  one-cycle buffer switch pulse
- busy_out  output  1  pixel write or clear in progress
- command_dropped_out  output  1  one-cycle pulse when a command is rejected

Behaviour:
Reset:
- Clock and reset: single clock; reset_in is synchronous and active-high.
- On reset, all outputs are 0, the FSM goes to IDLE and the pending-switch flag clears.
- Reset mid-clear abandons the fill immediately; the next cycle has pixel_write_enable_out = 0.

Operand sampling and transactions:
- An operand acts only on the first cycle of each operand_valid_in high period; the registered previous value provides edge detection.
- A transaction starts on the rising edge of op_code_valid_in.

Op codes:
- 0x10 assign color: operand 1 gives index; operand 2 bits [7:4] give value[9:6]; operand 3 bits [7:5] give value[5:3]; operand 4 bits [7:5] give value[2:0].
  - assign_color_enable_out pulses one cycle, the cycle after operand 4 is sampled; index and value stay stable during the pulse.
  - Accepted in any FSM state.
- 0x11 draw pixel: operands 1/2/3 give address bits [17:16], [15:8] and [7:0]; operand 4 bits [3:0] give color.
  - On operand 4 sampled in IDLE with address < PIXEL_COUNT, the FSM enters PIXEL next cycle.
  - If busy or address >= PIXEL_COUNT, the command is ignored and command_dropped_out pulses.
- 0x12 clear: operand 1 bits [3:0] give color.
  - In IDLE, the FSM enters CLEAR next cycle with counter = 0.
  - If busy, command_dropped_out pulses.
- 0x17 buffer show: acts on the transaction-start cycle and takes no operands.
  - In IDLE, switch_write_buffer_out pulses on the next cycle.
  - Otherwise the pending-switch flag is set; a second 0x17 while pending merges into it.
- Any other op code is ignored; no drop pulse.

FSM states:
- IDLE:
  - busy_out = 0 and write enable = 0.
  - If the pending flag is set, switch_write_buffer_out pulses one cycle and the flag clears.
- PIXEL:
  - enable = 1, address and data held stable.
  - The write is accepted on a cycle with enable && ready, then the FSM goes to IDLE.
  - With ready low, the FSM waits indefinitely.
- CLEAR:
  - enable = 1, address = counter, data = clear color.
  - On each accepted cycle the counter increments.
  - Acceptance at counter = PIXEL_COUNT-1 sends the FSM to IDLE.
  - The counter does not advance while ready is low.

Outputs and pending switch:
- busy_out = 1 in PIXEL and CLEAR.
- switch_write_buffer_out never coincides with pixel_write_enable_out.
- The pending switch is issued exactly one cycle after return to IDLE.

Address and counter widths:
- Addresses are unsigned; the counter is ADDRESS_WIDTH bits and never wraps, because the clear ends at PIXEL_COUNT-1.

Test Plan:
- Assign color: op 0x10, operands 0x05, 0xA0, 0x60, 0xE0 -> one-cycle assign_color_enable_out, index 0x05, value 10'b1010_011_111.
- Draw pixel with ready held low: op 0x11, operands 0x01, 0x23, 0x45, 0x0C, ready low 3 cycles then high -> enable held 4 cycles, address 0x12345, data 0xC; busy_out falls the cycle after the accept.
- Out-of-range pixel: op 0x11 with address 0x3FFFF -> no write; command_dropped_out pulses once.
- Clear with back-pressure: op 0x12, color 0x7, ready toggling 1/0 -> exactly 256000 accepted writes, addresses 0..255999 in order, then IDLE.
- Switch deferred by clear: 0x17 issued mid-clear, plus a second 0x17 -> a single switch_write_buffer_out pulse, one cycle after clear completes; 0x11 sent during the clear is dropped with a pulse.
- Reset mid-clear: assert reset_in at counter 1000 -> next cycle all outputs 0; a subsequent 0x17 pulses the switch in 1 cycle with no stale pending switch.
